// File: rtl/mem_req_arbiter_pkg.sv
// Shared state/owner encodings and memory message layout for mem_req_arbiter
// and the memory-side decoder.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int READ_LEN  = 5;
  localparam int WRITE_LEN = 9;

  // Read messages carry the address at bit 0; writes put wdata first.
  localparam int READ_ADDR_LO  = 0;
  localparam int WRITE_ADDR_LO = 32;
  localparam int WDATA_LO      = 0;
  localparam int MASK_LO       = 64;
  localparam int RW_BIT        = 32;

  localparam int LINE_BIT = 128;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  // With rotate set, a tie goes to the port that did not win last time.
  function automatic owner_t pickOwner(input logic   ifReq,
                                       input logic   memReq,
                                       input owner_t lastGrant,
                                       input logic   rotate);
    owner_t winner;
    if (ifReq && memReq) begin
      if (rotate) winner = (lastGrant == OWN_IF) ? OWN_MEM : OWN_IF;
      else        winner = OWN_MEM;
    end else if (memReq) begin
      winner = OWN_MEM;
    end else begin
      winner = OWN_IF;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_msg_pack.sv
// Combinational packing of a latched request into the comm message format.
// Module name mem_msg_pack; offsets come from the shared package.
module mem_msg_pack
  import mem_req_arbiter_pkg::*;
#(
  parameter int MSG_BIT = 256
) (
  input  logic               i_we,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_mask,
  output logic [4:0]         o_length,
  output logic [MSG_BIT-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_we) begin
      o_length                     = 5'(WRITE_LEN);
      o_data[WDATA_LO +: 32]       = i_wdata;
      o_data[WRITE_ADDR_LO +: 32]  = i_addr;
      o_data[MASK_LO +: 4]         = i_mask;
    end else begin
      o_length                     = 5'(READ_LEN);
      o_data[READ_ADDR_LO +: 32]   = i_addr;
      o_data[RW_BIT]               = 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// CPU-side memory request controller sharing one comm channel between IF and MEM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is MEM > IF.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MSG_BIT  = 256,
  parameter int RESP_LEN = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_ack,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_mask,
  output logic               mem_ack,
  output logic [127:0]       rdata,
  input  logic               tx_ready,
  output logic               tx_flag,
  output logic [4:0]         tx_length,
  output logic [MSG_BIT-1:0] tx_data,
  input  logic               rx_valid,
  input  logic [4:0]         rx_length,
  input  logic [MSG_BIT-1:0] rx_data,
  output logic               rx_pop,
  output logic               busy,
  output logic               len_err
);

  state_t                r_state;
  owner_t                r_owner;
  req_t                  r_req;
  logic                  r_ifAck;
  logic                  r_memAck;
  logic [LINE_BIT-1:0]   r_rdata;

  logic                  w_anyReq;
  owner_t                w_winner;
  logic                  w_lenOk;
  logic                  w_inSend;
  logic                  w_inWait;
  logic [4:0]            w_msgLen;
  logic [MSG_BIT-1:0]    w_msgData;
  logic [MSG_BIT-LINE_BIT-1:0] w_unusedRxHi;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t                r_lastGrant;

  always_comb w_winner = pickOwner(if_req, mem_req, r_lastGrant, 1'b1);
`else
  always_comb w_winner = pickOwner(if_req, mem_req, OWN_IF, 1'b0);
`endif

  assign w_anyReq     = if_req | mem_req;
  assign w_lenOk      = (rx_length == 5'(RESP_LEN));
  assign w_inSend     = (r_state == ST_SEND);
  assign w_inWait     = (r_state == ST_WAIT);
  assign w_unusedRxHi = rx_data[MSG_BIT-1:LINE_BIT];

  mem_msg_pack #(
    .MSG_BIT (MSG_BIT)
  ) u_pack (
    .i_we     (r_req.we),
    .i_addr   (r_req.addr),
    .i_wdata  (r_req.wdata),
    .i_mask   (r_req.mask),
    .o_length (w_msgLen),
    .o_data   (w_msgData)
  );

  // Handshake strobes must coincide with the partner's ready/valid, so they
  // are decoded from the state register; the message bus is quiet outside SEND.
  assign tx_flag   = w_inSend & tx_ready;
  assign tx_length = w_inSend ? w_msgLen  : '0;
  assign tx_data   = w_inSend ? w_msgData : '0;
  assign rx_pop    = w_inWait & rx_valid;
  assign len_err   = w_inWait & rx_valid & ~w_lenOk;
  assign busy      = (r_state != ST_IDLE);
  assign if_ack    = r_ifAck;
  assign mem_ack   = r_memAck;
  assign rdata     = r_rdata;

  // Acks are raised on entry to DONE so they are high exactly while in DONE;
  // the requester drops req on the edge that returns us to IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_IF;
      r_req    <= '0;
      r_ifAck  <= 1'b0;
      r_memAck <= 1'b0;
      r_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_lastGrant <= OWN_IF;
`endif
    end else begin
      r_ifAck  <= 1'b0;
      r_memAck <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_winner;
            if (w_winner == OWN_MEM) begin
              r_req.we    <= mem_we;
              r_req.addr  <= mem_addr;
              r_req.wdata <= mem_wdata;
              r_req.mask  <= mem_mask;
            end else begin
              r_req.we    <= 1'b0;
              r_req.addr  <= if_addr;
              r_req.wdata <= '0;
              r_req.mask  <= '0;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_lastGrant <= w_winner;
`endif
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (r_req.we) begin
              r_ifAck  <= (r_owner == OWN_IF);
              r_memAck <= (r_owner == OWN_MEM);
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (rx_valid && w_lenOk) begin
            r_rdata  <= rx_data[LINE_BIT-1:0];
            r_ifAck  <= (r_owner == OWN_IF);
            r_memAck <= (r_owner == OWN_MEM);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- CPU-side memory request controller.
- Shares the single UART message channel to the simulated memory between the instruction-fetch port (IF) and the data port (MEM).
- Serialises requests into the memory message formats, sends them through the multi-channel comm transmit side, and waits for 16-byte read responses.
- Returns one-cycle acknowledges to the requesters.

Parameters:
- MSG_BIT, 256, payload width of comm message bus.
- RESP_LEN, 16, expected read-response length in bytes.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF read request; held until if_ack.
- if_addr  in  32  IF byte address.
- if_ack  out  1  one-cycle pulse: IF read complete, rdata valid.
- mem_req  in  1  data request; held until mem_ack.
- mem_we  in  1  1=write, 0=read.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  write data.
- mem_mask  in  4  byte-enable, bit i -> byte i.
- mem_ack  out  1  one-cycle pulse: data request complete.
- rdata  out  128  last read line, byte 0 at [7:0].
- tx_ready  in  1  comm can accept a message.
- tx_flag  out  1  one-cycle send strobe.
- tx_length  out  5  message length in bytes.
- tx_data  out  MSG_BIT  message payload.
- rx_valid  in  1  response message available.
- rx_length  in  5  response length.
- rx_data  in  MSG_BIT  response payload.
- rx_pop  out  1  one-cycle consume strobe.
- busy  out  1  state != IDLE.
- len_err  out  1  one-cycle pulse: response length != RESP_LEN.

Behaviour:
- Reset values: all outputs 0, rdata=0, state=IDLE, last_grant=IF. Reset mid-transaction abandons it; no ack is issued.
- States: IDLE, SEND, WAIT, DONE.
- IDLE: if any req, pick a winner, latch its op/addr/wdata/mask and owner, go SEND.
  - Priority without option: MEM wins over IF.
- SEND: while tx_ready=0, hold state (tx_flag=0). When tx_ready=1, assert tx_flag for exactly that cycle with the message below.
  - Read: tx_length=5, tx_data[31:0]=addr, tx_data[32]=0, all other bits 0.
  - Write: tx_length=9, tx_data[31:0]=wdata, [63:32]=addr, [67:64]=mask, all other bits 0.
  - Next state: write -> DONE (writes get no response); read -> WAIT.
- WAIT: when rx_valid=1, assert rx_pop for one cycle.
  - rx_length==RESP_LEN: rdata<=rx_data[127:0], go DONE.
  - Otherwise: pulse len_err, discard the message, stay WAIT.
- DONE: pulse the owner's ack for one cycle, go IDLE.
  - Requesters drop req at the edge ending the ack, so IDLE never regrants a finished request.
- Minimum latency, req high to ack: write 3 cycles; read 4 cycles (tx_ready and rx_valid both already high).
- rdata is held until the next successful read. mem_ack for a write leaves rdata unchanged.
- rx_valid in IDLE/SEND/DONE is ignored (no pop).
- Request inputs change only between transactions; latched copies are used after IDLE.
- Never more than one outstanding request.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous if_req and mem_req in IDLE, grant the port not equal to last_grant. last_grant updates on every grant. A single requester is always granted.
- Undefined: fixed priority MEM > IF. last_grant register removed.

Decomposition:
- Shared package/header holds:
  - State encodings.
  - Message length constants: READ_LEN=5, WRITE_LEN=9.
  - Field offsets: ADDR_LO=0/32, WDATA_LO=0, MASK_LO=64, RW_BIT=32.
  - Owner encoding: OWN_IF=0, OWN_MEM=1.
- One natural sub-module, mem_msg_pack: combinational packing of {op, addr, wdata, mask} into tx_length/tx_data. Kept separate so the memory-side decoder shares offsets.

Test Plan:
- IF read only: if_addr=0x100, tx_ready=1; response length 16, data 0x0F0E..0100 -> tx_length=5, tx_data=0x100, bit32=0; rx_pop once; if_ack 4 cycles after req with rdata=0x0F0E0D0C0B0A09080706050403020100.
- MEM write: addr=0x2000, wdata=0xDEADBEEF, mask=0b0101 -> tx_length=9, tx_data[67:0]=0x5_00002000_DEADBEEF; mem_ack 3 cycles after req; rx_pop never asserted; rdata unchanged.
- Simultaneous if_req and mem_req (read 0x40), option off -> MEM served first, then IF. Option on with last_grant=MEM -> IF first.
- Backpressure: tx_ready low 5 cycles -> tx_flag stays 0, busy=1; single tx_flag pulse when tx_ready rises.
- Bad response length 9 in WAIT -> rx_pop and len_err pulse, no ack. A following length-16 message -> ack with its data.
- RST asserted during WAIT -> all outputs 0 asynchronously, no ack. After release, a new request completes normally.
